// File: rtl/gb_input_pkg.sv
// rtl/gb_input_pkg.sv - shared constants and sizing helper for button input blocks
package gb_input_pkg;

  // Counter behaviour at the limits: wrap around or clamp.
  localparam int MODE_WRAP     = 0;
  localparam int MODE_SATURATE = 1;

  // Ceiling log2, used to size debounce counters; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchroniser, debounce filter and press-edge pulse for one button
module button_debounce
  import gb_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic press_pulse
);

  localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          stable_prev;
  logic [CW-1:0] db_cnt;

  // Two-flop synchroniser for the asynchronous raw input.
  always_ff @(posedge clock) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Accept a new level only after it has differed from stable for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clock) begin
    if (rst) begin
      stable <= 1'b0;
      db_cnt <= '0;
    end else if (sync_b != stable) begin
      if (db_cnt == LAST_CNT) begin
        stable <= sync_b;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // One-cycle registered pulse on the 0->1 transition of the debounced level.
  always_ff @(posedge clock) begin
    if (rst) begin
      stable_prev <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      stable_prev <= stable;
      press_pulse <= stable & ~stable_prev;
    end
  end

endmodule

// File: rtl/debounced_updown_counter.sv
// rtl/debounced_updown_counter.sv - button-driven up/down counter with load, wrap/saturate and limit flags
module debounced_updown_counter
  import gb_input_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int MAX_VALUE       = 2**WIDTH - 1,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SATURATE        = 0
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             up_pulse,
  output logic             down_pulse,
  output logic             wrap_evt,
  output logic             at_min,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VALUE);

  logic             up_stable_unused;
  logic             down_stable_unused;
  logic [WIDTH-1:0] count_next;
  logic             wrap_next;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clock       (clock),
    .rst         (rst),
    .raw         (btn_up),
    .stable      (up_stable_unused),
    .press_pulse (up_pulse)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clock       (clock),
    .rst         (rst),
    .raw         (btn_down),
    .stable      (down_stable_unused),
    .press_pulse (down_pulse)
  );

  // Next count: load beats presses, simultaneous presses cancel, limits wrap or clamp.
  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    if (load) begin
      count_next = (load_value > MAX_CNT) ? MAX_CNT : load_value;
    end else if (up_pulse && down_pulse) begin
      count_next = count;
    end else if (up_pulse) begin
      if (count >= MAX_CNT) begin
        if (SATURATE == MODE_WRAP) begin
          count_next = '0;
          wrap_next  = 1'b1;
        end
      end else begin
        count_next = count + WIDTH'(1);
      end
    end else if (down_pulse) begin
      if (count == '0) begin
        if (SATURATE == MODE_WRAP) begin
          count_next = MAX_CNT;
          wrap_next  = 1'b1;
        end
      end else begin
        count_next = count - WIDTH'(1);
      end
    end
  end

  // Count register and its wrap flag, updated together so the flag coincides with the wrapped value.
  always_ff @(posedge clock) begin
    if (rst) begin
      count    <= '0;
      wrap_evt <= 1'b0;
    end else begin
      count    <= count_next;
      wrap_evt <= wrap_next;
    end
  end

  assign at_min = (count == '0);
  assign at_max = (count == MAX_CNT);

endmodule

// File: tb/tb_debounced_updown_counter.sv
// tb/tb_debounced_updown_counter.sv - directed table and sequence checks for debounced_updown_counter
module tb_debounced_updown_counter;

  localparam int DB = 4;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'd0;

  logic [7:0] w_count, s_count, b_count;
  logic       w_up, w_dn, w_wrap, w_min, w_max;
  logic       s_up, s_dn, s_wrap, s_min, s_max;
  logic       b_up, b_dn, b_wrap, b_min, b_max;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  debounced_updown_counter #(.WIDTH(8), .MAX_VALUE(9), .DEBOUNCE_CYCLES(DB), .SATURATE(0)) u_wrap (
    .clock(clock), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .load(load),
    .load_value(load_value), .count(w_count), .up_pulse(w_up), .down_pulse(w_dn),
    .wrap_evt(w_wrap), .at_min(w_min), .at_max(w_max)
  );

  debounced_updown_counter #(.WIDTH(8), .MAX_VALUE(9), .DEBOUNCE_CYCLES(DB), .SATURATE(1)) u_sat (
    .clock(clock), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .load(load),
    .load_value(load_value), .count(s_count), .up_pulse(s_up), .down_pulse(s_dn),
    .wrap_evt(s_wrap), .at_min(s_min), .at_max(s_max)
  );

  debounced_updown_counter #(.WIDTH(8), .MAX_VALUE(100), .DEBOUNCE_CYCLES(DB), .SATURATE(0)) u_big (
    .clock(clock), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .load(load),
    .load_value(load_value), .count(b_count), .up_pulse(b_up), .down_pulse(b_dn),
    .wrap_evt(b_wrap), .at_min(b_min), .at_max(b_max)
  );

  typedef struct {
    int op;     // 0 load, 1 up, 2 down, 3 both
    int val;
    int exp_w;
    int wev_w;
    int exp_s;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic do_load(input int v);
    @(negedge clock);
    load = 1'b1;
    load_value = 8'(v);
    @(posedge clock);
    #1;
    load = 1'b0;
  endtask

  task automatic press_begin(input logic u, input logic d);
    @(negedge clock);
    btn_up = u;
    btn_down = d;
    repeat (DB + 3) @(posedge clock);
    #1;
  endtask

  task automatic press_end();
    @(posedge clock);
    #1;
  endtask

  task automatic release_btns();
    @(negedge clock);
    btn_up = 1'b0;
    btn_down = 1'b0;
    repeat (DB + 4) @(posedge clock);
    #1;
  endtask

  task automatic check_hold(input int base);
    for (int i = 0; i <= DB + 8; i++) begin
      @(posedge clock);
      #1;
      chk($sformatf("hold_pulse[%0d]", i), int'(b_up), (i == DB + 2) ? 1 : 0);
      chk($sformatf("hold_count[%0d]", i), int'(b_count), (i >= DB + 3) ? base + 1 : base);
    end
  endtask

  initial begin
    int seen;

    tbl[0]  = '{0, 9, 9, 0, 9};
    tbl[1]  = '{1, 0, 0, 1, 9};
    tbl[2]  = '{2, 0, 9, 1, 8};
    tbl[3]  = '{0, 0, 0, 0, 0};
    tbl[4]  = '{2, 0, 9, 1, 0};
    tbl[5]  = '{1, 0, 0, 1, 1};
    tbl[6]  = '{0, 5, 5, 0, 5};
    tbl[7]  = '{3, 0, 5, 0, 5};
    tbl[8]  = '{1, 0, 6, 0, 6};
    tbl[9]  = '{2, 0, 5, 0, 5};
    tbl[10] = '{0, 15, 9, 0, 9};
    tbl[11] = '{0, 3, 3, 0, 3};

    repeat (3) @(posedge clock);
    #1;
    chk("rst_count", int'(w_count), 0);
    chk("rst_up_pulse", int'(w_up), 0);
    chk("rst_down_pulse", int'(w_dn), 0);
    chk("rst_wrap", int'(w_wrap), 0);
    chk("rst_at_min", int'(w_min), 1);
    chk("rst_at_max", int'(w_max), 0);
    chk("rst_big_count", int'(b_count), 0);
    @(negedge clock);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].op == 0) begin
        do_load(tbl[i].val);
      end else begin
        press_begin(tbl[i].op == 1 || tbl[i].op == 3, tbl[i].op == 2 || tbl[i].op == 3);
        chk($sformatf("v%0d_up_pulse", i), int'(w_up), (tbl[i].op == 1 || tbl[i].op == 3) ? 1 : 0);
        chk($sformatf("v%0d_down_pulse", i), int'(w_dn), (tbl[i].op == 2 || tbl[i].op == 3) ? 1 : 0);
        press_end();
      end
      chk($sformatf("v%0d_wrap_count", i), int'(w_count), tbl[i].exp_w);
      chk($sformatf("v%0d_wrap_evt", i), int'(w_wrap), tbl[i].wev_w);
      chk($sformatf("v%0d_wrap_min", i), int'(w_min), (tbl[i].exp_w == 0) ? 1 : 0);
      chk($sformatf("v%0d_wrap_max", i), int'(w_max), (tbl[i].exp_w == 9) ? 1 : 0);
      chk($sformatf("v%0d_sat_count", i), int'(s_count), tbl[i].exp_s);
      chk($sformatf("v%0d_sat_wrap_evt", i), int'(s_wrap), 0);
      chk($sformatf("v%0d_sat_min", i), int'(s_min), (tbl[i].exp_s == 0) ? 1 : 0);
      chk($sformatf("v%0d_sat_max", i), int'(s_max), (tbl[i].exp_s == 9) ? 1 : 0);
      if (tbl[i].op != 0) begin
        release_btns();
        chk($sformatf("v%0d_wrap_evt_cleared", i), int'(w_wrap), 0);
        chk($sformatf("v%0d_count_after_release", i), int'(w_count), tbl[i].exp_w);
      end
    end

    // Fresh start for the multi-cycle sequences on the MAX_VALUE=100 instance.
    @(negedge clock);
    rst = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst = 1'b0;

    // Hold: exactly one pulse after full latency, no further increments while held.
    @(negedge clock);
    btn_up = 1'b1;
    check_hold(0);
    release_btns();
    chk("hold_release_count", int'(b_count), 1);

    // Glitches shorter than the debounce window are ignored.
    seen = 0;
    for (int r = 0; r < 5; r++) begin
      @(negedge clock);
      btn_up = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(posedge clock);
        #1;
        if (b_up || b_dn) seen = seen + 1;
      end
      @(negedge clock);
      btn_up = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(posedge clock);
        #1;
        if (b_up || b_dn) seen = seen + 1;
      end
    end
    for (int c = 0; c < DB + 4; c++) begin
      @(posedge clock);
      #1;
      if (b_up || b_dn) seen = seen + 1;
    end
    chk("glitch_pulses", seen, 0);
    chk("glitch_count", int'(b_count), 1);

    // Simultaneous presses cancel.
    do_load(5);
    chk("sim_load_count", int'(b_count), 5);
    press_begin(1'b1, 1'b1);
    chk("sim_up_pulse", int'(b_up), 1);
    chk("sim_down_pulse", int'(b_dn), 1);
    press_end();
    chk("sim_count", int'(b_count), 5);
    release_btns();

    // Load above the limit clamps to MAX_VALUE.
    do_load(200);
    chk("load_clamp_count", int'(b_count), 100);
    chk("load_clamp_at_max", int'(b_max), 1);
    chk("load_clamp_at_min", int'(b_min), 0);

    // Reset in the middle of a debounce window, button held across release.
    @(negedge clock);
    btn_up = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    rst = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("midrst_count", int'(b_count), 0);
    chk("midrst_up_pulse", int'(b_up), 0);
    chk("midrst_down_pulse", int'(b_dn), 0);
    @(negedge clock);
    rst = 1'b0;
    check_hold(0);
    release_btns();
    chk("midrst_final_count", int'(b_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debounced_updown_counter.md
# debounced_updown_counter

Parametrised button-driven up/down counter with per-input synchronisation, debounce and press-edge detection, wrap or saturate mode, synchronous load and limit flags. It replaces ad-hoc key counting logic in the top level. It sits between raw board inputs (KEY/GPIO buttons, already inverted to active-high by the instantiator) and consumers such as HexController displays or settings registers.

## Interface

- WIDTH, 8, counter width in bits (1..16)
- MAX_VALUE, 2**WIDTH-1, upper count limit; must be <= 2**WIDTH-1
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a level change (>= 1)
- SATURATE, 0, 0 = wrap between 0 and MAX_VALUE, 1 = clamp at 0 / MAX_VALUE
- clock  in  1  sole clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- btn_up  in  1  raw asynchronous up button, active-high
- btn_down  in  1  raw asynchronous down button, active-high
- load  in  1  synchronous load strobe
- load_value  in  WIDTH  value loaded when load=1
- count  out  WIDTH  current count
- up_pulse  out  1  one-cycle pulse on accepted up press
- down_pulse  out  1  one-cycle pulse on accepted down press
- wrap_evt  out  1  one-cycle pulse when count wrapped (SATURATE=0 only)
- at_min  out  1  count == 0 (combinational from count)
- at_max  out  1  count == MAX_VALUE (combinational from count)

## Operation

- Per input channel: 2-flop synchroniser -> debounce -> rising-edge detect.
- Debounce: register `stable` plus counter `db_cnt` (width clog2(DEBOUNCE_CYCLES+1)). When synced != stable, db_cnt increments; when db_cnt == DEBOUNCE_CYCLES-1 and still differing, stable <= synced, db_cnt <= 0. When synced == stable, db_cnt <= 0 (any glitch restarts the window).
- Press pulse: registered, high for exactly one cycle after stable goes 0->1. Release (1->0) produces no pulse. Holding a button produces one pulse only.
- Count update, priority order per cycle:
  1. rst: count <= 0.
  2. load: count <= min(load_value, MAX_VALUE); pending pulses that cycle are discarded.
  3. up_pulse && down_pulse: no change.
  4. up_pulse: count == MAX_VALUE -> 0 and wrap_evt=1 (wrap) or hold (saturate); else count+1.
  5. down_pulse: count == 0 -> MAX_VALUE and wrap_evt=1 (wrap) or hold (saturate); else count-1.
- Arithmetic in WIDTH bits; never exceeds MAX_VALUE, including when MAX_VALUE < 2**WIDTH-1.
- wrap_evt is never asserted when SATURATE=1.

## Timing

- Reset values: count=0, up_pulse=0, down_pulse=0, wrap_evt=0, at_min=1, at_max=(MAX_VALUE==0), sync flops=0, stable=0, db_cnt=0.
- Button held high from edge t: synced high after edge t+2; stable high after edge t+1+DEBOUNCE_CYCLES... specifically stable rises at edge t+2+DEBOUNCE_CYCLES-1 = t+1+DEBOUNCE_CYCLES; pulse high during the following cycle (set at edge t+2+DEBOUNCE_CYCLES); count updated at edge t+3+DEBOUNCE_CYCLES; wrap_evt asserted in the same cycle count shows the wrapped value.
- Load: count reflects value one cycle after load sampled.
- Reset mid-debounce: all debounce state cleared; a button held across reset release is treated as a new press and pulses after full latency.
- Button pulse shorter than DEBOUNCE_CYCLES synced cycles: ignored.

## Structure

- Shared package gb_input_pkg: SATURATE mode constants (MODE_WRAP=0, MODE_SATURATE=1) and clog2 helper function for debounce counter sizing; reused by snes_controller successors.
- Sub-module button_debounce (parameter DEBOUNCE_CYCLES; ports clock, rst, raw, stable, press_pulse), instantiated twice; counter logic in debounced_updown_counter.

## Test plan

- WIDTH=8, DEBOUNCE_CYCLES=4: hold btn_up high from edge 10 -> up_pulse high only in cycle after edge 16, count=1 after edge 17, no further increments while held.
- Glitch: btn_up high for 3 cycles, low, repeated 5 times -> no pulses, count stays 0.
- SATURATE=0, MAX_VALUE=9: load 9, one up press -> count=0 with wrap_evt high one cycle; down press from 0 -> count=9, wrap_evt high.
- SATURATE=1, MAX_VALUE=9: at 9 up press -> stays 9, at_max=1, wrap_evt=0; at 0 down press -> stays 0, at_min=1.
- Simultaneous press: btn_up and btn_down rise same cycle from count=5 -> both pulses, count stays 5; load=1 with load_value=200 and MAX_VALUE=100 -> count=100.
- Assert rst during debounce window with btn_up held -> count=0, pulses 0; after release of rst, pulse occurs exactly after full debounce latency, count=1.
